lzw_cam_array: RTL and testbench

LZW_CAM_ARRAY -- requirements
Module: lzw_cam_array

---
 rtl/lzw_cam_array_pkg.sv | 16 +
 rtl/lzw_cam_array_if.sv | 30 +++
 rtl/lzw_cam_entry.sv | 37 +++
 rtl/lzw_cam_array.sv | 111 +++++++++++
 tb/tb_lzw_cam_array.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/lzw_cam_array_pkg.sv
// lzw_pkg: shared defaults and key/code types for the LZW dictionary CAM.
//   CAM_WIDTH_DEF  : stored key width (11-bit prefix code + 8-bit character)
//   NUM_ENTRY_DEF  : number of dictionary entries
//   FIRST_CODE_DEF : code of entry 0 (codes below it are literal bytes)
//   CODE_W_DEF     : width of an output code
package lzw_pkg;

  localparam int CAM_WIDTH_DEF  = 19;
  localparam int NUM_ENTRY_DEF  = 1792;
  localparam int FIRST_CODE_DEF = 256;
  localparam int CODE_W_DEF     = $clog2(FIRST_CODE_DEF + NUM_ENTRY_DEF);

  typedef logic [CODE_W_DEF-1:0]    code_t;
  typedef logic [CAM_WIDTH_DEF-1:0] key_t;

endpackage

// File: rtl/lzw_cam_array_if.sv
// lzw_cam_array_if: request/response bus of the LZW dictionary CAM.
//   req_valid/req_ready/search_key : lookup-or-insert request
//   rsp_valid/hit/inserted/match_code : registered response
// master = requester side, slave = CAM side.
interface lzw_cam_array_if
  import lzw_pkg::*;
#(
  parameter int CAM_WIDTH = CAM_WIDTH_DEF,
  parameter int CODE_W    = CODE_W_DEF
);

  logic                 req_valid;
  logic                 req_ready;
  logic [CAM_WIDTH-1:0] search_key;
  logic                 rsp_valid;
  logic                 hit;
  logic                 inserted;
  logic [CODE_W-1:0]    match_code;

  modport master (
    output req_valid, search_key,
    input  req_ready, rsp_valid, hit, inserted, match_code
  );

  modport slave (
    input  req_valid, search_key,
    output req_ready, rsp_valid, hit, inserted, match_code
  );

endinterface

// File: rtl/lzw_cam_entry.sv
// lzw_cam_entry: one dictionary slot.
//   clk, rst (async, active-low), clear (sync flush of the valid bit)
//   we         : capture search_key and mark the slot valid
//   search_key : key being looked up (also the write data)
//   match      : slot valid and stored key equals search_key
module lzw_cam_entry
  import lzw_pkg::*;
#(
  parameter int CAM_WIDTH = CAM_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 we,
  input  logic [CAM_WIDTH-1:0] search_key,
  output logic                 match
);

  logic [CAM_WIDTH-1:0] key_q;
  logic                 vld_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q <= '0;
      vld_q <= 1'b0;
    end else if (clear) begin
      // Flush only invalidates; the stale key is unreachable until rewritten.
      vld_q <= 1'b0;
    end else if (we) begin
      key_q <= search_key;
      vld_q <= 1'b1;
    end
  end

  assign match = vld_q && (key_q == search_key);

endmodule

// File: rtl/lzw_cam_array.sv
// lzw_cam_array: LZW dictionary CAM with lookup-or-insert semantics.
//   clk, rst (async, active-low)
//   clear      : synchronous dictionary flush; blocks acceptance that cycle
//   bus        : lzw_cam_array_if slave (request in, registered response out)
//   full       : registered, all entries valid
//   count      : number of valid entries
// A request is compared combinationally against every slot in its acceptance
// cycle; a miss writes the next free slot on the same edge, so a request in
// the following cycle already sees it.
module lzw_cam_array
  import lzw_pkg::*;
#(
  parameter int CAM_WIDTH  = CAM_WIDTH_DEF,
  parameter int NUM_ENTRY  = NUM_ENTRY_DEF,
  parameter int FIRST_CODE = FIRST_CODE_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  lzw_cam_array_if.slave           bus,
  output logic                     full,
  output logic [$clog2(FIRST_CODE+NUM_ENTRY):0] count
);

  localparam int CODE_W = $clog2(FIRST_CODE + NUM_ENTRY);
  localparam int CNT_W  = CODE_W + 1;
  localparam int IDX_W  = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1;

  logic [NUM_ENTRY-1:0] match_vec;
  logic [NUM_ENTRY-1:0] we_vec;
  logic [IDX_W-1:0]     hit_idx;
  logic                 any_hit;
  logic                 accept;
  logic                 ins_en;
  logic [CNT_W-1:0]     cnt_nxt;

  logic                 vld_p1;
  logic                 hit_p1;
  logic                 inserted_p1;
  logic [CODE_W-1:0]    code_p1;

  assign bus.req_ready = !clear;
  assign accept        = bus.req_valid && !clear;
  assign any_hit       = |match_vec;
  assign ins_en        = accept && !any_hit && !full;
  assign cnt_nxt       = count + 1'b1;

  for (genvar g = 0; g < NUM_ENTRY; g++) begin : g_entry
    // Slots fill in index order, so the next free slot is always entry[count].
    assign we_vec[g] = ins_en && (count == CNT_W'(g));

    lzw_cam_entry #(
      .CAM_WIDTH (CAM_WIDTH)
    ) u_entry (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .we         (we_vec[g]),
      .search_key (bus.search_key),
      .match      (match_vec[g])
    );
  end

  // Lowest-index priority encoder: scan downward so the lowest match wins.
  always_comb begin
    hit_idx = '0;
    for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
      if (match_vec[i]) hit_idx = IDX_W'(i);
    end
  end

  // ---- stage p1: registered response, occupancy and full flag ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1      <= 1'b0;
      hit_p1      <= 1'b0;
      inserted_p1 <= 1'b0;
      code_p1     <= '0;
      count       <= '0;
      full        <= 1'b0;
    end else if (clear) begin
      // Response payload holds its last value; only the pulse is dropped.
      vld_p1 <= 1'b0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        hit_p1      <= any_hit;
        inserted_p1 <= ins_en;
        if (any_hit) begin
          code_p1 <= CODE_W'(FIRST_CODE) + CODE_W'(hit_idx);
        end else if (!full) begin
          code_p1 <= CODE_W'(FIRST_CODE) + CODE_W'(count);
        end else begin
          code_p1 <= '0;
        end
      end
      if (ins_en) begin
        count <= cnt_nxt;
        full  <= (cnt_nxt == CNT_W'(NUM_ENTRY));
      end
    end
  end

  assign bus.rsp_valid  = vld_p1;
  assign bus.hit        = hit_p1;
  assign bus.inserted   = inserted_p1;
  assign bus.match_code = code_p1;

endmodule

// File: tb/tb_lzw_cam_array.sv
// tb_lzw_cam_array: directed bench for lzw_cam_array built with 4 entries.
module tb_lzw_cam_array;

  localparam int CAM_WIDTH  = 19;
  localparam int NUM_ENTRY  = 4;
  localparam int FIRST_CODE = 256;
  localparam int CODE_W     = $clog2(FIRST_CODE + NUM_ENTRY);

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              full;
  logic [CODE_W:0]   count;
  int                errors = 0;
  int                checks = 0;

  lzw_cam_array_if #(.CAM_WIDTH(CAM_WIDTH), .CODE_W(CODE_W)) bus ();

  lzw_cam_array #(
    .CAM_WIDTH  (CAM_WIDTH),
    .NUM_ENTRY  (NUM_ENTRY),
    .FIRST_CODE (FIRST_CODE)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus.slave),
    .full  (full),
    .count (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    @(negedge clk);
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; bus.req_valid = 1'b0; bus.search_key = '0;
    #2 rst = 1'b0;
    #5;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0h want 0", bus.rsp_valid); end
    checks++; if (bus.hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %0h want 0", bus.hit); end
    checks++; if (bus.inserted !== 1'b0) begin errors++; $display("FAIL reset_inserted got %0h want 0", bus.inserted); end
    checks++; if (bus.match_code !== 0) begin errors++; $display("FAIL reset_code got %0d want 0", bus.match_code); end
    checks++; if (count !== 0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0h want 0", full); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0h want 1", bus.req_ready); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL idle_rsp_valid got %0h want 0", bus.rsp_valid); end
  endtask

  task automatic test_first_insert();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.search_key = 19'h00041;
    tick();
    bus.req_valid = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL ins_rsp_valid got %0h want 1", bus.rsp_valid); end
    checks++; if (bus.hit !== 1'b0) begin errors++; $display("FAIL ins_hit got %0h want 0", bus.hit); end
    checks++; if (bus.inserted !== 1'b1) begin errors++; $display("FAIL ins_inserted got %0h want 1", bus.inserted); end
    checks++; if (bus.match_code !== 256) begin errors++; $display("FAIL ins_code got %0d want 256", bus.match_code); end
    checks++; if (count !== 1) begin errors++; $display("FAIL ins_count got %0d want 1", count); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL ins_pulse got %0h want 0", bus.rsp_valid); end
    checks++; if (bus.inserted !== 1'b1 || bus.match_code !== 256) begin errors++; $display("FAIL ins_hold got ins=%0h code=%0d want ins=1 code=256", bus.inserted, bus.match_code); end
  endtask

  task automatic test_back_to_back();
    flush();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.search_key = 19'h00041;
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.inserted !== 1'b1 || bus.hit !== 1'b0 || bus.match_code !== 256) begin
      errors++; $display("FAIL b2b_first got v=%0h ins=%0h hit=%0h code=%0d want v=1 ins=1 hit=0 code=256", bus.rsp_valid, bus.inserted, bus.hit, bus.match_code); end
    tick();
    bus.req_valid = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.inserted !== 1'b0 || bus.hit !== 1'b1 || bus.match_code !== 256) begin
      errors++; $display("FAIL b2b_second got v=%0h ins=%0h hit=%0h code=%0d want v=1 ins=0 hit=1 code=256", bus.rsp_valid, bus.inserted, bus.hit, bus.match_code); end
    checks++; if (count !== 1) begin errors++; $display("FAIL b2b_count got %0d want 1", count); end
  endtask

  task automatic test_full();
    flush();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b1; bus.search_key = 19'h00041 + 19'(i);
      tick();
      checks++; if (bus.inserted !== 1'b1 || bus.match_code !== 256 + i) begin
        errors++; $display("FAIL fill_%0d got ins=%0h code=%0d want ins=1 code=%0d", i, bus.inserted, bus.match_code, 256 + i); end
      checks++; if (count !== i + 1 || full !== (i == 3)) begin
        errors++; $display("FAIL fill_occ_%0d got count=%0d full=%0h want count=%0d full=%0d", i, count, full, i + 1, (i == 3)); end
    end
    @(negedge clk);
    bus.search_key = 19'h00045;
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.hit !== 1'b0 || bus.inserted !== 1'b0 || bus.match_code !== 0) begin
      errors++; $display("FAIL full_miss got v=%0h hit=%0h ins=%0h code=%0d want v=1 hit=0 ins=0 code=0", bus.rsp_valid, bus.hit, bus.inserted, bus.match_code); end
    checks++; if (count !== 4 || full !== 1'b1) begin errors++; $display("FAIL full_occ got count=%0d full=%0h want 4/1", count, full); end
    @(negedge clk);
    bus.search_key = 19'h00043;
    tick();
    bus.req_valid = 1'b0;
    checks++; if (bus.hit !== 1'b1 || bus.inserted !== 1'b0 || bus.match_code !== 258) begin
      errors++; $display("FAIL full_old_hit got hit=%0h ins=%0h code=%0d want hit=1 ins=0 code=258", bus.hit, bus.inserted, bus.match_code); end
  endtask

  task automatic test_clear_with_req();
    @(negedge clk);
    clear = 1'b1; bus.req_valid = 1'b1; bus.search_key = 19'h00099;
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL clr_ready got %0h want 0", bus.req_ready); end
    tick();
    clear = 1'b0; bus.req_valid = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL clr_rsp got %0h want 0", bus.rsp_valid); end
    checks++; if (count !== 0 || full !== 1'b0) begin errors++; $display("FAIL clr_occ got count=%0d full=%0h want 0/0", count, full); end
    checks++; if (bus.match_code !== 258 || bus.hit !== 1'b1) begin errors++; $display("FAIL clr_hold got code=%0d hit=%0h want 258/1", bus.match_code, bus.hit); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL clr_no_rsp got %0h want 0", bus.rsp_valid); end
    @(negedge clk);
    bus.req_valid = 1'b1; bus.search_key = 19'h00043;
    tick();
    bus.req_valid = 1'b0;
    checks++; if (bus.inserted !== 1'b1 || bus.hit !== 1'b0 || bus.match_code !== 256 || count !== 1) begin
      errors++; $display("FAIL clr_reinsert got ins=%0h hit=%0h code=%0d count=%0d want 1/0/256/1", bus.inserted, bus.hit, bus.match_code, count); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.search_key = 19'h00041;
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.inserted !== 1'b1 || bus.match_code !== 257) begin
      errors++; $display("FAIL ar_pre got v=%0h ins=%0h code=%0d want 1/1/257", bus.rsp_valid, bus.inserted, bus.match_code); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.hit !== 1'b0 || bus.inserted !== 1'b0 || bus.match_code !== 0) begin
      errors++; $display("FAIL ar_rsp got v=%0h hit=%0h ins=%0h code=%0d want all 0", bus.rsp_valid, bus.hit, bus.inserted, bus.match_code); end
    checks++; if (count !== 0 || full !== 1'b0) begin errors++; $display("FAIL ar_occ got count=%0d full=%0h want 0/0", count, full); end
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++; if (bus.rsp_valid !== 1'b0 || count !== 0) begin errors++; $display("FAIL ar_stale got v=%0h count=%0d want 0/0", bus.rsp_valid, count); end
    @(negedge clk);
    bus.req_valid = 1'b1; bus.search_key = 19'h00043;
    tick();
    bus.req_valid = 1'b0;
    checks++; if (bus.inserted !== 1'b1 || bus.match_code !== 256) begin
      errors++; $display("FAIL ar_reinsert got ins=%0h code=%0d want 1/256", bus.inserted, bus.match_code); end
  endtask

  initial begin
    test_reset();
    test_first_insert();
    test_back_to_back();
    test_full();
    test_clear_with_req();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
